io_bus_target: RTL and testbench
================================

// Module: io_bus_target
// PURPOSE
// IO-device end of the system bus. One instance sits behind each bit k of the bus io_read_en/io_write_en vectors.
// - Its io_rdata drives bus_data_read_premux[k].
// - Decodes bus_addr into a small register bank plus a TX FIFO (bus->device) and an RX FIFO (device->bus).
// - Provides a valid/ready stream interface to the attached peripheral and a level interrupt.
// PARAMETERS
// DATA_W      32  bus data width (matches MEM_WIDTH)
// ADDR_W      8   word-address width of bus_addr decoded here (matches MEM_DEPTH)
// FIFO_DEPTH  8   entries per FIFO; power of two, >=2
// PORTS
// clk            in   1            system clock, all logic on posedge
// rst            in   1            asynchronous, active-low reset
// io_sel_rd      in   1            this device's io_read_en bit; one-cycle read strobe
// io_sel_wr      in   1            this device's io_write_en bit; one-cycle write strobe
// bus_addr       in   ADDR_W       register word address, valid while a strobe is high
// bus_data_write in   DATA_W       write data, valid while io_sel_wr is high
// io_rdata       out  DATA_W       read data to bus_data_read_premux[k]
// dev_tx_data    out  DATA_W       TX FIFO head toward peripheral
// dev_tx_valid   out  1            TX head valid
// dev_tx_ready   in   1            peripheral accepts TX head
// dev_rx_data    in   DATA_W       data from peripheral
// dev_rx_valid   in   1            peripheral offers data
// dev_rx_ready   out  1            RX FIFO accepts
// irq            out  1            registered level interrupt
// access_err     out  1            one-cycle pulse on illegal or unmapped access
// BEHAVIOUR
// Register map (bus_addr):
//   0 CTRL    rw  [0] enable, [1] fifo_clr (self-clearing, reads 0), [2] irq_en
//   1 STATUS  ro/W1C  [0] rx_empty, [1] rx_full, [2] tx_empty, [3] tx_full,
//                     [4] ovf sticky (W1C), [5] udf sticky (W1C), [15:8] rx_count
//   2 TXDATA  wo  push to TX FIFO; reads return 0
//   3 RXDATA  ro  pop from RX FIFO; writes ignored
//   4 SCRATCH rw  full DATA_W
//   Other addresses: reads return 0, writes are dropped, access_err pulses.
// Reads:
//   - io_rdata is combinational, zero wait state: mux(bus_addr) while io_sel_rd=1, else 0.
//   - Read side effects (RX pop) take effect at the posedge ending the strobe cycle.
// Writes:
//   - Register/FIFO update occurs at the posedge where io_sel_wr=1.
//   - A STATUS read in the following cycle reflects the new state.
// io_sel_rd and io_sel_wr both high: read served, write dropped, access_err=1 next cycle.
// Counters and pointers:
//   - Pointers are log2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH.
//   - Counts are log2(FIFO_DEPTH)+1 bits.
//   - A push and a pop in the same cycle leave the count unchanged; this is legal even when the FIFO is full or holds 1 entry.
// TX FIFO:
//   - Push on write to TXDATA.
//   - If full and no same-cycle device pop: data dropped, ovf<=1.
//   - dev_tx_valid = enable & !tx_empty; dev_tx_data = head; pop on dev_tx_valid & dev_tx_ready.
// RX FIFO:
//   - dev_rx_ready = enable & !rx_full; push on dev_rx_valid & dev_rx_ready.
//   - RXDATA read when empty: io_rdata=0, udf<=1, no pop.
//   - No bypass: a same-cycle device push into an empty FIFO still counts as underflow.
// enable=0: stream handshakes are blocked, but the bus still accesses all registers and TXDATA pushes are still accepted.
// fifo_clr write:
//   - Both FIFOs are emptied at that edge; any same-cycle push/pop is discarded.
//   - ovf/udf are unchanged.
// W1C and sticky set in the same cycle: set wins.
// irq is registered: irq <= irq_en & (!rx_empty | ovf | udf).
// Reset (rst=0, asynchronous):
//   - CTRL, SCRATCH, ovf and udf are 0; pointers and counts are 0.
//   - Outputs: io_rdata=0, dev_tx_valid=0, dev_tx_data=0, dev_rx_ready=0, irq=0, access_err=0.
//   - A reset asserted mid-strobe aborts the access with no side effect.
// TESTING
// 1. Reset, then read addr 0..5 -> 0,0x5,0,0,0,0; access_err=1 only for addr 5.
// 2. CTRL=0x1; write TXDATA 0xA1..0xA8 with dev_tx_ready=0 -> STATUS[3]=1; 9th write -> ovf=1, FIFO still A1..A8.
//    Then drive dev_tx_ready=1 -> A1..A8 out in order.
// 3. dev_rx pushes 0x11,0x22 -> STATUS[15:8]=2; RXDATA reads 0x11,0x22; third read -> 0 and udf=1.
//    irq=1 one cycle after udf when irq_en=1; W1C 0x20 to STATUS -> udf=0.
// 4. Full TX plus simultaneous TXDATA write and device pop -> count stays 8, no ovf; wrap checked over 3 full FIFO passes.
// 5. Read and write strobes together on SCRATCH -> old value read, SCRATCH unchanged, access_err pulse.
// 6. fifo_clr with both FIFOs non-empty -> both empty next cycle; rst low mid-strobe -> all outputs 0 immediately.

Source files
------------

// File: rtl/io_bus_target.sv
// IO bus target: CTRL/STATUS/SCRATCH registers, a TX FIFO toward the
// peripheral and an RX FIFO from it, level irq and access_err pulse.
//
// Ports:
//   clk, rst             clock, async active-low reset
//   io_sel_rd/io_sel_wr  one-cycle bus read/write strobes
//   bus_addr             register word address
//   bus_data_write       write data
//   io_rdata             combinational read data (0 when no read)
//   dev_tx_*             TX stream toward the peripheral (valid/ready)
//   dev_rx_*             RX stream from the peripheral (valid/ready)
//   irq                  registered level interrupt
//   access_err           one-cycle pulse on unmapped or conflicting access
module io_bus_target #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 8,
  parameter int FIFO_DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              io_sel_rd,
  input  logic              io_sel_wr,
  input  logic [ADDR_W-1:0] bus_addr,
  input  logic [DATA_W-1:0] bus_data_write,
  output logic [DATA_W-1:0] io_rdata,
  output logic [DATA_W-1:0] dev_tx_data,
  output logic              dev_tx_valid,
  input  logic              dev_tx_ready,
  input  logic [DATA_W-1:0] dev_rx_data,
  input  logic              dev_rx_valid,
  output logic              dev_rx_ready,
  output logic              irq,
  output logic              access_err
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

  logic              en_q, irq_en_q;
  logic [DATA_W-1:0] scratch_q;
  logic              ovf_q, udf_q;
  logic              irq_q, err_q;

  logic [DATA_W-1:0] tx_mem [FIFO_DEPTH];
  logic [DATA_W-1:0] rx_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  tx_wp_q, tx_rp_q, rx_wp_q, rx_rp_q;
  logic [CNT_W-1:0]  tx_cnt_q, rx_cnt_q;

  logic [PTR_W-1:0]  tx_wp_d, tx_rp_d, rx_wp_d, rx_rp_d;
  logic [CNT_W-1:0]  tx_cnt_d, rx_cnt_d;
  logic              ovf_d, udf_d, irq_d, err_d;

  logic hit_ctrl, hit_stat, hit_tx, hit_rx, hit_scr, mapped;
  logic wr_ok, clr;
  logic tx_empty, tx_full, rx_empty, rx_full;
  logic tx_req, tx_push, tx_pop, ovf_set;
  logic rx_req, rx_push, rx_pop, udf_set;
  logic [DATA_W-1:0] status, rdata_mux;

  assign hit_ctrl = bus_addr == ADDR_W'(0);
  assign hit_stat = bus_addr == ADDR_W'(1);
  assign hit_tx   = bus_addr == ADDR_W'(2);
  assign hit_rx   = bus_addr == ADDR_W'(3);
  assign hit_scr  = bus_addr == ADDR_W'(4);
  assign mapped   = bus_addr <  ADDR_W'(5);

  // A read that collides with a write wins; the write is dropped.
  assign wr_ok = io_sel_wr & ~io_sel_rd;
  assign clr   = wr_ok & hit_ctrl & bus_data_write[1];

  assign tx_empty = tx_cnt_q == '0;
  assign tx_full  = tx_cnt_q == FULL_CNT;
  assign rx_empty = rx_cnt_q == '0;
  assign rx_full  = rx_cnt_q == FULL_CNT;

  assign tx_pop  = en_q & ~tx_empty & dev_tx_ready;
  assign tx_req  = wr_ok & hit_tx;
  // A full FIFO still accepts when the head leaves in the same cycle.
  assign tx_push = tx_req & (~tx_full | tx_pop);
  assign ovf_set = tx_req & tx_full & ~tx_pop;

  assign rx_push = dev_rx_ready & dev_rx_valid;
  assign rx_req  = io_sel_rd & hit_rx;
  assign rx_pop  = rx_req & ~rx_empty;
  // No bypass: a push landing this cycle does not satisfy the read.
  assign udf_set = rx_req & rx_empty;

  always_comb begin
    tx_wp_d  = tx_wp_q + PTR_W'(tx_push);
    tx_rp_d  = tx_rp_q + PTR_W'(tx_pop);
    tx_cnt_d = tx_cnt_q + CNT_W'(tx_push) - CNT_W'(tx_pop);
    rx_wp_d  = rx_wp_q + PTR_W'(rx_push);
    rx_rp_d  = rx_rp_q + PTR_W'(rx_pop);
    rx_cnt_d = rx_cnt_q + CNT_W'(rx_push) - CNT_W'(rx_pop);
    if (clr) begin
      tx_wp_d  = '0;
      tx_rp_d  = '0;
      tx_cnt_d = '0;
      rx_wp_d  = '0;
      rx_rp_d  = '0;
      rx_cnt_d = '0;
    end
  end

  // Sticky set beats a same-cycle W1C.
  always_comb begin
    ovf_d = ovf_q;
    udf_d = udf_q;
    if (wr_ok & hit_stat) begin
      ovf_d = ovf_q & ~bus_data_write[4];
      udf_d = udf_q & ~bus_data_write[5];
    end
    ovf_d = ovf_d | ovf_set;
    udf_d = udf_d | udf_set;
  end

  assign irq_d = irq_en_q & (~rx_empty | ovf_q | udf_q);
  assign err_d = (io_sel_rd | io_sel_wr) &
                 (~mapped | (io_sel_rd & io_sel_wr));

  always_comb begin
    status        = '0;
    status[0]     = rx_empty;
    status[1]     = rx_full;
    status[2]     = tx_empty;
    status[3]     = tx_full;
    status[4]     = ovf_q;
    status[5]     = udf_q;
    status[15:8]  = 8'(rx_cnt_q);
  end

  always_comb begin
    rdata_mux = '0;
    unique case (1'b1)
      hit_ctrl: rdata_mux = DATA_W'({irq_en_q, 1'b0, en_q});
      hit_stat: rdata_mux = status;
      hit_rx:   rdata_mux = rx_empty ? '0 : rx_mem[rx_rp_q];
      hit_scr:  rdata_mux = scratch_q;
      default:  rdata_mux = '0;
    endcase
  end

  // Gated by rst so a read strobe held through reset returns 0.
  assign io_rdata     = (rst & io_sel_rd) ? rdata_mux : '0;
  assign dev_tx_valid = en_q & ~tx_empty;
  assign dev_tx_data  = tx_empty ? '0 : tx_mem[tx_rp_q];
  assign dev_rx_ready = en_q & ~rx_full;
  assign irq          = irq_q;
  assign access_err   = err_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      en_q      <= 1'b0;
      irq_en_q  <= 1'b0;
      scratch_q <= '0;
      ovf_q     <= 1'b0;
      udf_q     <= 1'b0;
      irq_q     <= 1'b0;
      err_q     <= 1'b0;
      tx_wp_q   <= '0;
      tx_rp_q   <= '0;
      tx_cnt_q  <= '0;
      rx_wp_q   <= '0;
      rx_rp_q   <= '0;
      rx_cnt_q  <= '0;
    end else begin
      if (wr_ok & hit_ctrl) begin
        en_q     <= bus_data_write[0];
        irq_en_q <= bus_data_write[2];
      end
      if (wr_ok & hit_scr) scratch_q <= bus_data_write;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
      irq_q    <= irq_d;
      err_q    <= err_d;
      tx_wp_q  <= tx_wp_d;
      tx_rp_q  <= tx_rp_d;
      tx_cnt_q <= tx_cnt_d;
      rx_wp_q  <= rx_wp_d;
      rx_rp_q  <= rx_rp_d;
      rx_cnt_q <= rx_cnt_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        tx_mem[i] <= '0;
        rx_mem[i] <= '0;
      end
    end else begin
      if (tx_push & ~clr) tx_mem[tx_wp_q] <= bus_data_write;
      if (rx_push & ~clr) rx_mem[rx_wp_q] <= dev_rx_data;
    end
  end

endmodule

// File: tb/tb_io_bus_target.sv
// Testbench for io_bus_target: directed scenarios plus a randomized
// run against a queue-based register/FIFO model.
module tb_io_bus_target;

  logic        clk = 1'b0;
  logic        rst;
  logic        io_sel_rd, io_sel_wr;
  logic [7:0]  bus_addr;
  logic [31:0] bus_data_write;
  logic [31:0] io_rdata;
  logic [31:0] dev_tx_data;
  logic        dev_tx_valid, dev_tx_ready;
  logic [31:0] dev_rx_data;
  logic        dev_rx_valid, dev_rx_ready;
  logic        irq, access_err;

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  io_bus_target #(.DATA_W(32), .ADDR_W(8), .FIFO_DEPTH(8)) dut (
    .clk(clk), .rst(rst),
    .io_sel_rd(io_sel_rd), .io_sel_wr(io_sel_wr),
    .bus_addr(bus_addr), .bus_data_write(bus_data_write),
    .io_rdata(io_rdata),
    .dev_tx_data(dev_tx_data), .dev_tx_valid(dev_tx_valid),
    .dev_tx_ready(dev_tx_ready),
    .dev_rx_data(dev_rx_data), .dev_rx_valid(dev_rx_valid),
    .dev_rx_ready(dev_rx_ready),
    .irq(irq), .access_err(access_err)
  );

  task automatic do_reset();
    rst = 1'b0;
    io_sel_rd = 0; io_sel_wr = 0; bus_addr = 0; bus_data_write = 0;
    dev_tx_ready = 0; dev_rx_valid = 0; dev_rx_data = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic bus_write(input logic [7:0] a, input logic [31:0] d);
    io_sel_wr = 1; bus_addr = a; bus_data_write = d;
    @(posedge clk); #1;
    io_sel_wr = 0;
  endtask

  task automatic bus_read(input logic [7:0] a, output logic [31:0] r);
    io_sel_rd = 1; bus_addr = a;
    #1 r = io_rdata;
    @(posedge clk); #1;
    io_sel_rd = 0;
  endtask

  task automatic test_reset();
    logic [31:0] r;
    logic [31:0] exp_tab [6] = '{32'h0, 32'h5, 32'h0, 32'h0, 32'h0, 32'h0};
    do_reset();
    total_cnt++;
    if ({dev_tx_valid, dev_rx_ready, irq, access_err} !== 4'b0 ||
        dev_tx_data !== 32'h0)
      $display("FAIL reset_outs got v%b r%b i%b e%b d%h exp zeros",
               dev_tx_valid, dev_rx_ready, irq, access_err, dev_tx_data);
    else pass_cnt++;
    for (int a = 0; a < 6; a++) begin
      bus_read(8'(a), r);
      total_cnt++;
      if (r !== exp_tab[a])
        $display("FAIL reset_rd%0d got %h exp %h", a, r, exp_tab[a]);
      else pass_cnt++;
      total_cnt++;
      if (access_err !== (a == 5))
        $display("FAIL reset_err%0d got %b exp %b", a, access_err, a == 5);
      else pass_cnt++;
    end
  endtask

  task automatic test_tx_ovf();
    logic [31:0] r;
    do_reset();
    bus_write(8'd0, 32'h1);
    for (int i = 1; i <= 8; i++) bus_write(8'd2, 32'hA0 + i);
    bus_read(8'd1, r);
    total_cnt++;
    if (r !== 32'h9) $display("FAIL tx_full_stat got %h exp %h", r, 32'h9);
    else pass_cnt++;
    bus_write(8'd2, 32'hA9);
    bus_read(8'd1, r);
    total_cnt++;
    if (r !== 32'h19) $display("FAIL tx_ovf_stat got %h exp %h", r, 32'h19);
    else pass_cnt++;
    dev_tx_ready = 1;
    for (int i = 1; i <= 8; i++) begin
      total_cnt++;
      if (dev_tx_valid !== 1'b1 || dev_tx_data !== 32'hA0 + i)
        $display("FAIL tx_drain%0d got v%b %h exp %h",
                 i, dev_tx_valid, dev_tx_data, 32'hA0 + i);
      else pass_cnt++;
      @(posedge clk); #1;
    end
    total_cnt++;
    if (dev_tx_valid !== 1'b0)
      $display("FAIL tx_drained got %b exp 0", dev_tx_valid);
    else pass_cnt++;
    dev_tx_ready = 0;
  endtask

  task automatic test_rx_udf_irq();
    logic [31:0] r;
    logic [31:0] exp_rd [3] = '{32'h11, 32'h22, 32'h0};
    do_reset();
    bus_write(8'd0, 32'h5);
    dev_rx_valid = 1; dev_rx_data = 32'h11;
    total_cnt++;
    if (dev_rx_ready !== 1'b1) $display("FAIL rx_ready got %b exp 1", dev_rx_ready);
    else pass_cnt++;
    @(posedge clk); #1;
    dev_rx_data = 32'h22;
    @(posedge clk); #1;
    dev_rx_valid = 0;
    bus_read(8'd1, r);
    total_cnt++;
    if (r[15:8] !== 8'd2) $display("FAIL rx_count got %0d exp 2", r[15:8]);
    else pass_cnt++;
    total_cnt++;
    if (irq !== 1'b1) $display("FAIL irq_rx got %b exp 1", irq);
    else pass_cnt++;
    for (int i = 0; i < 3; i++) begin
      bus_read(8'd3, r);
      total_cnt++;
      if (r !== exp_rd[i]) $display("FAIL rx_rd%0d got %h exp %h", i, r, exp_rd[i]);
      else pass_cnt++;
    end
    total_cnt++;
    if (irq !== 1'b0) $display("FAIL irq_pre_udf got %b exp 0", irq);
    else pass_cnt++;
    @(posedge clk); #1;
    total_cnt++;
    if (irq !== 1'b1) $display("FAIL irq_udf got %b exp 1", irq);
    else pass_cnt++;
    bus_read(8'd1, r);
    total_cnt++;
    if (r !== 32'h25) $display("FAIL udf_stat got %h exp %h", r, 32'h25);
    else pass_cnt++;
    bus_write(8'd1, 32'h20);
    bus_read(8'd1, r);
    total_cnt++;
    if (r !== 32'h5) $display("FAIL udf_w1c got %h exp %h", r, 32'h5);
    else pass_cnt++;
    total_cnt++;
    if (irq !== 1'b0) $display("FAIL irq_clear got %b exp 0", irq);
    else pass_cnt++;
  endtask

  task automatic test_tx_wrap();
    logic [31:0] q [$];
    logic [31:0] r, v;
    do_reset();
    bus_write(8'd0, 32'h1);
    for (int i = 0; i < 8; i++) begin
      v = $urandom;
      q.push_back(v);
      bus_write(8'd2, v);
    end
    for (int k = 0; k < 24; k++) begin
      v = $urandom;
      io_sel_wr = 1; bus_addr = 8'd2; bus_data_write = v;
      dev_tx_ready = 1;
      #1;
      total_cnt++;
      if (dev_tx_valid !== 1'b1 || dev_tx_data !== q[0])
        $display("FAIL wrap%0d got v%b %h exp %h", k, dev_tx_valid, dev_tx_data, q[0]);
      else pass_cnt++;
      void'(q.pop_front());
      q.push_back(v);
      @(posedge clk); #1;
    end
    io_sel_wr = 0; dev_tx_ready = 0;
    bus_read(8'd1, r);
    total_cnt++;
    if (r !== 32'h9) $display("FAIL wrap_stat got %h exp %h", r, 32'h9);
    else pass_cnt++;
    total_cnt++;
    if (dev_tx_data !== q[0]) $display("FAIL wrap_head got %h exp %h", dev_tx_data, q[0]);
    else pass_cnt++;
  endtask

  task automatic test_rw_conflict();
    logic [31:0] r;
    do_reset();
    bus_write(8'd4, 32'hDEADBEEF);
    io_sel_rd = 1; io_sel_wr = 1; bus_addr = 8'd4; bus_data_write = 32'h12345678;
    #1;
    total_cnt++;
    if (io_rdata !== 32'hDEADBEEF)
      $display("FAIL rw_read got %h exp %h", io_rdata, 32'hDEADBEEF);
    else pass_cnt++;
    @(posedge clk); #1;
    io_sel_rd = 0; io_sel_wr = 0;
    total_cnt++;
    if (access_err !== 1'b1) $display("FAIL rw_err got %b exp 1", access_err);
    else pass_cnt++;
    bus_read(8'd4, r);
    total_cnt++;
    if (r !== 32'hDEADBEEF) $display("FAIL rw_scratch got %h exp %h", r, 32'hDEADBEEF);
    else pass_cnt++;
    total_cnt++;
    if (access_err !== 1'b0) $display("FAIL rw_err_end got %b exp 0", access_err);
    else pass_cnt++;
  endtask

  task automatic test_clr_reset();
    logic [31:0] r;
    do_reset();
    bus_write(8'd0, 32'h1);
    bus_write(8'd2, 32'h77);
    bus_write(8'd2, 32'h78);
    dev_rx_valid = 1; dev_rx_data = 32'h99;
    @(posedge clk); #1;
    dev_rx_valid = 0;
    bus_read(8'd1, r);
    total_cnt++;
    if (r !== 32'h100) $display("FAIL clr_pre got %h exp %h", r, 32'h100);
    else pass_cnt++;
    bus_write(8'd0, 32'h3);
    bus_read(8'd1, r);
    total_cnt++;
    if (r !== 32'h5) $display("FAIL clr_stat got %h exp %h", r, 32'h5);
    else pass_cnt++;
    bus_read(8'd0, r);
    total_cnt++;
    if (r !== 32'h1) $display("FAIL clr_ctrl got %h exp %h", r, 32'h1);
    else pass_cnt++;
    bus_write(8'd0, 32'h5);
    bus_write(8'd4, 32'h55);
    bus_write(8'd2, 32'h66);
    dev_rx_valid = 1; dev_rx_data = 32'h44;
    @(posedge clk); #1;
    io_sel_rd = 1; bus_addr = 8'd7;
    @(posedge clk); #1;
    bus_addr = 8'd4;
    #1 rst = 1'b0;
    #1;
    total_cnt++;
    if (io_rdata !== 32'h0 || dev_tx_data !== 32'h0 ||
        {dev_tx_valid, dev_rx_ready, irq, access_err} !== 4'b0)
      $display("FAIL midrst got rd%h td%h v%b r%b i%b e%b exp zeros",
               io_rdata, dev_tx_data, dev_tx_valid, dev_rx_ready, irq, access_err);
    else pass_cnt++;
    io_sel_rd = 0; dev_rx_valid = 0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    bus_read(8'd4, r);
    total_cnt++;
    if (r !== 32'h0) $display("FAIL midrst_scr got %h exp 0", r);
    else pass_cnt++;
    bus_read(8'd1, r);
    total_cnt++;
    if (r !== 32'h5) $display("FAIL midrst_stat got %h exp %h", r, 32'h5);
    else pass_cnt++;
  endtask

  task automatic test_random();
    logic [31:0] txq [$];
    logic [31:0] rxq [$];
    bit m_en, m_ien, m_ovf, m_udf, m_irq, m_err;
    logic [31:0] m_scr, exp_rd, d;
    bit rd, wr, clr, tpop, rpush, rreq, tpreq, oset, uset;
    int a, sel;
    do_reset();
    m_en = 0; m_ien = 0; m_ovf = 0; m_udf = 0; m_irq = 0; m_err = 0; m_scr = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      sel = $urandom_range(0, 9);
      rd = (sel <= 3) || (sel == 8);
      wr = (sel >= 4 && sel <= 8);
      a = $urandom_range(0, 6);
      d = $urandom;
      if (a == 0) begin
        d = d & 32'h5;
        d[0] = ($urandom_range(0, 3) != 0);
        d[1] = ($urandom_range(0, 15) == 0);
      end
      io_sel_rd = rd; io_sel_wr = wr; bus_addr = 8'(a); bus_data_write = d;
      dev_tx_ready = ($urandom_range(0, 3) == 0);
      dev_rx_valid = $urandom_range(0, 1);
      dev_rx_data = $urandom;
      #1;
      exp_rd = 0;
      if (rd) begin
        case (a)
          0: exp_rd = {29'b0, m_ien, 1'b0, m_en};
          1: exp_rd = {16'b0, 8'(rxq.size()), 2'b0, m_udf, m_ovf,
                       txq.size() == 8, txq.size() == 0,
                       rxq.size() == 8, rxq.size() == 0};
          3: exp_rd = (rxq.size() > 0) ? rxq[0] : 32'h0;
          4: exp_rd = m_scr;
          default: exp_rd = 0;
        endcase
      end
      total_cnt++;
      if (io_rdata !== exp_rd)
        $display("FAIL rnd_rdata c%0d a%0d got %h exp %h", cyc, a, io_rdata, exp_rd);
      else pass_cnt++;
      total_cnt++;
      if (dev_tx_valid !== (m_en && txq.size() > 0))
        $display("FAIL rnd_txv c%0d got %b exp %b", cyc, dev_tx_valid, m_en && txq.size() > 0);
      else pass_cnt++;
      if (txq.size() > 0) begin
        total_cnt++;
        if (dev_tx_data !== txq[0])
          $display("FAIL rnd_txd c%0d got %h exp %h", cyc, dev_tx_data, txq[0]);
        else pass_cnt++;
      end
      total_cnt++;
      if (dev_rx_ready !== (m_en && rxq.size() < 8))
        $display("FAIL rnd_rxr c%0d got %b exp %b", cyc, dev_rx_ready, m_en && rxq.size() < 8);
      else pass_cnt++;
      clr   = wr && !rd && a == 0 && d[1];
      tpop  = m_en && txq.size() > 0 && dev_tx_ready;
      rpush = m_en && rxq.size() < 8 && dev_rx_valid;
      rreq  = rd && a == 3;
      uset  = rreq && rxq.size() == 0;
      tpreq = wr && !rd && a == 2;
      oset  = tpreq && txq.size() == 8 && !tpop;
      m_irq = m_ien && (rxq.size() > 0 || m_ovf || m_udf);
      m_err = (rd || wr) && (a > 4 || (rd && wr));
      if (clr) begin
        txq.delete();
        rxq.delete();
      end else begin
        if (tpop) void'(txq.pop_front());
        if (tpreq && !oset) txq.push_back(d);
        if (rreq && !uset) void'(rxq.pop_front());
        if (rpush) rxq.push_back(dev_rx_data);
      end
      if (wr && !rd && a == 1) begin
        if (d[4]) m_ovf = 0;
        if (d[5]) m_udf = 0;
      end
      if (oset) m_ovf = 1;
      if (uset) m_udf = 1;
      if (wr && !rd && a == 0) begin
        m_en = d[0];
        m_ien = d[2];
      end
      if (wr && !rd && a == 4) m_scr = d;
      @(posedge clk); #1;
      total_cnt++;
      if (irq !== m_irq) $display("FAIL rnd_irq c%0d got %b exp %b", cyc, irq, m_irq);
      else pass_cnt++;
      total_cnt++;
      if (access_err !== m_err)
        $display("FAIL rnd_err c%0d got %b exp %b", cyc, access_err, m_err);
      else pass_cnt++;
    end
    io_sel_rd = 0; io_sel_wr = 0; dev_tx_ready = 0; dev_rx_valid = 0;
  endtask

  initial begin
    test_reset();
    test_tx_ovf();
    test_rx_udf_irq();
    test_tx_wrap();
    test_rw_conflict();
    test_clr_reset();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
